// File: rtl/range_fft_sequencer_if.sv
// rtl/range_fft_sequencer_if.sv - sample, FFT data and FFT config stream bundle for the range-FFT sequencer
interface range_fft_sequencer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] in_tdata;
    logic              in_tvalid;
    logic              in_tready;
    logic [DATA_W-1:0] fft_tdata;
    logic              fft_tvalid;
    logic              fft_tready;
    logic              fft_tlast;
    logic [15:0]       cfg_tdata;
    logic              cfg_tvalid;
    logic              cfg_tready;

    // master: the sequencer itself; slave: the streamer/FFT environment around it
    modport master (
        input  in_tdata, in_tvalid, fft_tready, cfg_tready,
        output in_tready, fft_tdata, fft_tvalid, fft_tlast, cfg_tdata, cfg_tvalid
    );

    modport slave (
        output in_tdata, in_tvalid, fft_tready, cfg_tready,
        input  in_tready, fft_tdata, fft_tvalid, fft_tlast, cfg_tdata, cfg_tvalid
    );
endinterface

// File: rtl/range_fft_sequencer.sv
// rtl/range_fft_sequencer.sv - frame controller: one FFT config word, then CHIRPS x FRAME_LENGTH samples with per-chirp tlast
module range_fft_sequencer #(
    parameter int         FRAME_LENGTH = 128,
    parameter int         CHIRPS       = 64,
    parameter int         DATA_W       = 32,
    parameter logic [9:0] SCALE_SCH    = 10'h2AA
) (
    input  logic                    clk,
    input  logic                    rst_n,
    range_fft_sequencer_if.master   io,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    evt_tlast_unexpected,
    input  logic                    evt_tlast_missing,
    output logic                    busy,
    output logic [7:0]              chirp_idx,
    output logic                    frame_done,
    output logic                    err
);

    localparam int              SW          = $clog2(FRAME_LENGTH);
    localparam logic [SW-1:0]   LAST_SAMPLE = SW'(FRAME_LENGTH - 1);
    localparam logic [7:0]      LAST_CHIRP  = 8'(CHIRPS - 1);
    localparam logic [15:0]     CFG_WORD    = {5'b0, SCALE_SCH, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        CFG,
        STREAM,
        DONE
    } state_t;

    state_t            state;
    logic [SW-1:0]     sample_cnt;
    logic              abort_pend;
    logic              cfg_tvalid_r;
    logic [15:0]       cfg_tdata_r;

    logic              streaming;
    logic              at_last;
    logic              xfer;
    logic [DATA_W-1:0] pass_data;

    // The data path is a pure passthrough gated by the registered state, so
    // in_tready depends only on fft_tready and never on in_tvalid.
    assign streaming = (state == STREAM);
    assign at_last   = (sample_cnt == LAST_SAMPLE);
    assign xfer      = streaming && io.in_tvalid && io.fft_tready;
    assign pass_data = io.in_tdata;

    assign io.in_tready  = streaming && io.fft_tready;
    assign io.fft_tvalid = streaming && io.in_tvalid;
    assign io.fft_tdata  = streaming ? pass_data : '0;
    assign io.fft_tlast  = streaming && io.in_tvalid && at_last;
    assign io.cfg_tvalid = cfg_tvalid_r;
    assign io.cfg_tdata  = cfg_tdata_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sample_cnt   <= '0;
            chirp_idx    <= '0;
            abort_pend   <= 1'b0;
            cfg_tvalid_r <= 1'b0;
            cfg_tdata_r  <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            err          <= 1'b0;
        end else begin
            // An event pulse beats a simultaneous clearing start.
            if (evt_tlast_unexpected || evt_tlast_missing) begin
                err <= 1'b1;
            end else if (state == IDLE && start) begin
                err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    if (start) begin
                        state        <= CFG;
                        sample_cnt   <= '0;
                        chirp_idx    <= '0;
                        abort_pend   <= 1'b0;
                        cfg_tvalid_r <= 1'b1;
                        cfg_tdata_r  <= CFG_WORD;
                        busy         <= 1'b1;
                    end
                end

                CFG: begin
                    // The config valid is never withdrawn; abort waits for the handshake.
                    if (abort) begin
                        abort_pend <= 1'b1;
                    end
                    if (io.cfg_tready) begin
                        cfg_tvalid_r <= 1'b0;
                        cfg_tdata_r  <= '0;
                        if (abort || abort_pend) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            abort_pend <= 1'b0;
                        end else begin
                            state <= STREAM;
                        end
                    end
                end

                STREAM: begin
                    if (abort) begin
                        abort_pend <= 1'b1;
                    end
                    if (xfer) begin
                        if (at_last) begin
                            sample_cnt <= '0;
                            // Abort only takes effect on a chirp boundary.
                            if (abort || abort_pend) begin
                                state      <= IDLE;
                                busy       <= 1'b0;
                                chirp_idx  <= '0;
                                abort_pend <= 1'b0;
                            end else if (chirp_idx == LAST_CHIRP) begin
                                state      <= DONE;
                                chirp_idx  <= '0;
                                frame_done <= 1'b1;
                            end else begin
                                chirp_idx <= chirp_idx + 8'd1;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + SW'(1);
                        end
                    end
                end

                DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
